bus_mux_arbiter: RTL and testbench
==================================

// Module: bus_mux_arbiter
// PURPOSE
//  Parametrised datapath bus driver: selects one of NUM_SRC source words onto the shared bus.
//  Replaces the fixed 24-input priority mux in the datapath.
//  Adds round-robin arbitration, optional registered output and hold-last-value on idle.
//  Adds multi-driver conflict detection with a sticky flag and a saturating count.
//  Sits between register-file/special-register outputs and every bus consumer; driven by control unit.
// PARAMETERS
//  DATA_W     32  width of each source word and of the bus
//  NUM_SRC    24  number of sources (2..32); index 0 = R0 ... per datapath source map
//  RR_MODE    0   0 = fixed priority (lowest index wins); 1 = round-robin
//  REG_OUT    1   1 = bus_out/grant/bus_valid registered (latency 1); 0 = combinational (latency 0)
//  HOLD_LAST  0   1 = bus_out keeps last driven word when idle; 0 = bus_out = 0 when idle
//  CNT_W      8   width of conflict_cnt
// PORTS
//  clock         in   1               system clock, all state on rising edge
//  clear         in   1               synchronous, active-high reset
//  src_data      in   NUM_SRC*DATA_W  flattened source words; source i at [i*DATA_W +: DATA_W]
//  src_out       in   NUM_SRC         drive requests (Rxout, HIout, ... Cout), bit i = source i
//  conflict_clr  in   1               clears conflict and conflict_cnt
//  bus_out       out  DATA_W          bus value
//  bus_valid     out  1               1 when bus_out carries a granted source this cycle
//  grant         out  NUM_SRC         one-hot granted source, all-zero when idle
//  conflict      out  1               sticky: >1 src_out bit seen since last clear/conflict_clr
//  conflict_cnt  out  CNT_W           saturating count of conflict cycles
// BEHAVIOUR
//  Reset (clear=1 at edge):
//   - bus_out, grant, bus_valid, conflict and conflict_cnt all go to 0.
//   - rr_ptr goes to 0; any held value is discarded.
//   - clear overrides every other input in that cycle.
//  Selection (combinational, from src_out):
//   - RR_MODE=0: grant the lowest set index.
//   - RR_MODE=1: search indices rr_ptr, rr_ptr+1, ..., NUM_SRC-1, 0, ... (mod NUM_SRC); grant the first set bit.
//   - Only the granted word reaches the bus; no OR-ing of sources.
//  rr_ptr:
//   - On a cycle with a grant k, rr_ptr <= (k+1) mod NUM_SRC; k=NUM_SRC-1 wraps to 0.
//   - Unchanged on idle cycles. Unused when RR_MODE=0.
//  Idle (src_out == 0):
//   - grant = 0 and bus_valid = 0.
//   - bus_out = 0 if HOLD_LAST=0; otherwise the last granted word.
//  Latency:
//   - REG_OUT=1: bus_out, grant and bus_valid reflect the request sampled at the previous edge.
//   - REG_OUT=0: same outputs, combinational, in the same cycle.
//   - The HOLD_LAST register exists in both modes.
//  Conflict:
//   - A cycle with popcount(src_out) >= 2 is a conflict cycle.
//   - The grant proceeds normally; a conflict never blocks the bus.
//   - Each conflict cycle, at the edge: conflict <= 1; conflict_cnt increments and saturates at 2^CNT_W-1.
//   - conflict_clr alone: conflict <= 0, conflict_cnt <= 0.
//   - conflict_clr together with a conflict cycle: conflict <= 1, conflict_cnt <= 1 (new event wins).
//   - conflict and conflict_cnt are always registered, independent of REG_OUT.
//  Other rules:
//   - Single request: behaves as a plain mux; rr_ptr still advances.
//   - Reset mid-transfer: the output is lost, and the next request after clear is arbitrated from rr_ptr=0.
//   - All index arithmetic is modulo NUM_SRC; no X propagates from unselected sources.
// TESTING
//  1) Reset: clear=1 with src_out=all-ones -> next cycle bus_out=0, grant=0, bus_valid=0, conflict=0, cnt=0.
//  2) Fixed priority, REG_OUT=1: src_out bits 3 and 7 set, data3=32'hDEAD_0003
//     -> one cycle later: bus_out=32'hDEAD_0003, grant=1<<3, conflict=1, cnt=1.
//  3) RR, NUM_SRC=24: src_out bits {5,20} held 4 cycles
//     -> grants 5, 20, 5, 20; then request bit 23 only -> grant 23 and rr_ptr wraps to 0.
//  4) HOLD_LAST=1: drive src 2 = 32'h1234_5678 for 1 cycle, then idle 3 cycles
//     -> bus_out stays 32'h1234_5678 and bus_valid=0; with HOLD_LAST=0 -> bus_out=0.
//  5) Saturation, CNT_W=4: 20 consecutive conflict cycles -> conflict_cnt=15.
//     Then conflict_clr together with a conflict cycle -> conflict=1, cnt=1; next idle cycle with clr -> 0.
//  6) REG_OUT=0: src_out=1<<21 (MDR), data=32'hCAFE_F00D -> same-cycle bus_out=32'hCAFE_F00D, bus_valid=1.

Source files
------------

// File: rtl/bus_mux_arbiter.sv
// Purpose: drives one of NUM_SRC source words onto the shared datapath bus, flags multi-driver conflicts.
// Latency: bus_out/grant/bus_valid 1 cycle when REG_OUT=1, same cycle when REG_OUT=0; conflict flags always 1 cycle.
// Backpressure: none; requests are never stalled, a losing source is simply not granted that cycle.
module bus_mux_arbiter #(
  parameter int DATA_W    = 32,
  parameter int NUM_SRC   = 24,
  parameter int RR_MODE   = 0,
  parameter int REG_OUT   = 1,
  parameter int HOLD_LAST = 0,
  parameter int CNT_W     = 8
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_out,
  input  logic                        conflict_clr,
  output logic [DATA_W-1:0]           bus_out,
  output logic                        bus_valid,
  output logic [NUM_SRC-1:0]          grant,
  output logic                        conflict,
  output logic [CNT_W-1:0]            conflict_cnt
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  // Everything the bus presents to consumers in one cycle.
  typedef struct packed {
    logic [DATA_W-1:0]  word;
    logic [NUM_SRC-1:0] grant;
    logic               valid;
  } busBeat_t;

  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   selIdx;
  logic [IDX_W-1:0]   nextPtr;
  logic               selHit;
  logic [DATA_W-1:0]  selWord;
  logic [NUM_SRC-1:0] selGrant;
  logic [DATA_W-1:0]  holdWord;
  logic [DATA_W-1:0]  idleWord;
  logic               multiReq;
  busBeat_t           selBeat;
  busBeat_t           outBeat;

  // Search for the first requester, starting at rrPtr in round-robin mode or at 0 in fixed-priority mode.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] candIdx;
    cand    = 0;
    candIdx = '0;
    selHit  = 1'b0;
    selIdx  = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      cand = (RR_MODE != 0) ? (int'(rrPtr) + off) : off;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      candIdx = IDX_W'(cand);
      if (!selHit && src_out[candIdx]) begin
        selHit = 1'b1;
        selIdx = candIdx;
      end
    end
  end

  // Steer only the granted word and build the one-hot grant; unselected sources never reach the bus.
  always_comb begin
    selWord  = '0;
    selGrant = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (selHit && (selIdx == IDX_W'(i))) begin
        selWord     = src_data[i*DATA_W +: DATA_W];
        selGrant[i] = 1'b1;
      end
    end
  end

  // Two or more drive requests in the same cycle; x & (x-1) clears the lowest set bit.
  assign multiReq = |(src_out & (src_out - NUM_SRC'(1)));

  // Pointer moves just past the winner, wrapping from the last source back to 0.
  assign nextPtr  = (selIdx == LAST_IDX) ? '0 : (selIdx + IDX_W'(1));

  // Value the bus shows when nobody drives it.
  assign idleWord = (HOLD_LAST != 0) ? holdWord : '0;

  // Beat as it would appear with zero latency.
  always_comb begin
    selBeat.word  = selHit ? selWord : idleWord;
    selBeat.grant = selGrant;
    selBeat.valid = selHit;
  end

  // Round-robin pointer: advances past each grant, stays put on idle cycles.
  always_ff @(posedge clock) begin
    if (clear) begin
      rrPtr <= '0;
    end else if (selHit) begin
      rrPtr <= nextPtr;
    end
  end

  // Last granted word, kept for hold-last-value on idle cycles.
  always_ff @(posedge clock) begin
    if (clear) begin
      holdWord <= '0;
    end else if (selHit) begin
      holdWord <= selWord;
    end
  end

  // Sticky conflict flag and saturating conflict counter; a new conflict beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (multiReq) begin
      conflict <= 1'b1;
      if (conflict_clr) begin
        conflict_cnt <= CNT_W'(1);
      end else if (conflict_cnt != CNT_MAX) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end else if (conflict_clr) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end
  end

  generate
    if (REG_OUT != 0) begin : gRegOut
      // Registered bus: outputs reflect the request sampled at the previous edge.
      always_ff @(posedge clock) begin
        if (clear) begin
          outBeat <= '0;
        end else begin
          outBeat <= selBeat;
        end
      end
    end else begin : gCombOut
      // Combinational bus: same-cycle outputs, forced idle while clear is asserted.
      always_comb begin
        outBeat = clear ? '0 : selBeat;
      end
    end
  endgenerate

  assign bus_out   = outBeat.word;
  assign grant     = outBeat.grant;
  assign bus_valid = outBeat.valid;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed bench: two arbiter configurations share one stimulus stream.
// dutF: fixed priority, registered outputs, idle bus = 0.  dutR: round-robin, combinational, hold-last.
// Expected outputs per cycle are queued by the stimulus and compared by a negedge monitor.
module tb_bus_mux_arbiter;

  localparam int DW = 32;
  localparam int NS = 24;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clear;
  logic              conflictClr;
  logic [NS*DW-1:0]  srcData;
  logic [NS-1:0]     srcOut;

  logic [DW-1:0] busF, busR;
  logic          validF, validR;
  logic [NS-1:0] grantF, grantR;
  logic          conflF, conflR;
  logic [CW-1:0] cntF, cntR;

  bus_mux_arbiter #(.DATA_W(DW), .NUM_SRC(NS), .RR_MODE(0), .REG_OUT(1), .HOLD_LAST(0), .CNT_W(CW)) dutF (
    .clock(clk), .clear(clear), .src_data(srcData), .src_out(srcOut), .conflict_clr(conflictClr),
    .bus_out(busF), .bus_valid(validF), .grant(grantF), .conflict(conflF), .conflict_cnt(cntF)
  );

  bus_mux_arbiter #(.DATA_W(DW), .NUM_SRC(NS), .RR_MODE(1), .REG_OUT(0), .HOLD_LAST(1), .CNT_W(CW)) dutR (
    .clock(clk), .clear(clear), .src_data(srcData), .src_out(srcOut), .conflict_clr(conflictClr),
    .bus_out(busR), .bus_valid(validR), .grant(grantR), .conflict(conflR), .conflict_cnt(cntR)
  );

  // Expected observation for one cycle; grant index -1 means idle.
  typedef struct {
    int          gF;
    logic [31:0] bF;
    int          gR;
    logic [31:0] bR;
    logic        c;
    int          n;
  } expT;

  expT   expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [31:0] word(int i);
    case (i)
      2:       return 32'h1234_5678;
      3:       return 32'hDEAD_0003;
      21:      return 32'hCAFE_F00D;
      default: return {16'hA5A5, 16'(i)};
    endcase
  endfunction

  function automatic logic [31:0] oneHot(int g);
    logic [31:0] one;
    one = 32'd1;
    return (g < 0) ? 32'd0 : (one << g);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin : mon
    expT   e;
    string nm;
    if (expQ.size() > 0) begin
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      chk({nm, ".F.bus"},   busF,                oneHot(-1) | e.bF);
      chk({nm, ".F.grant"}, {8'b0, grantF},      oneHot(e.gF));
      chk({nm, ".F.valid"}, {31'b0, validF},     {31'b0, (e.gF >= 0)});
      chk({nm, ".F.confl"}, {31'b0, conflF},     {31'b0, e.c});
      chk({nm, ".F.cnt"},   {28'b0, cntF},       32'(e.n));
      chk({nm, ".R.bus"},   busR,                e.bR);
      chk({nm, ".R.grant"}, {8'b0, grantR},      oneHot(e.gR));
      chk({nm, ".R.valid"}, {31'b0, validR},     {31'b0, (e.gR >= 0)});
      chk({nm, ".R.confl"}, {31'b0, conflR},     {31'b0, e.c});
      chk({nm, ".R.cnt"},   {28'b0, cntR},       32'(e.n));
    end
  end

  // Queue what both DUTs must show this cycle, apply inputs, advance one clock.
  task automatic step(string nm, bit clr, bit cc, logic [NS-1:0] src,
                      int gF, logic [31:0] bF, int gR, logic [31:0] bR, bit c, int n);
    expT e;
    e.gF = gF; e.bF = bF; e.gR = gR; e.bR = bR; e.c = c; e.n = n;
    expQ.push_back(e);
    nameQ.push_back(nm);
    clear       = clr;
    conflictClr = cc;
    srcOut      = src;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) srcData[i*DW +: DW] = word(i);
    clear       = 1'b1;
    conflictClr = 1'b0;
    srcOut      = '1;
    repeat (2) @(posedge clk);
    #1;

    //    name       clr cc src          F:g  F:bus     R:g  R:bus     c  n
    step("idle0",    0, 0, 24'h000000,  -1, 0,        -1, 0,        0, 0);
    step("fp2",      0, 0, 24'h000088,  -1, 0,         3, word(3),  0, 0);
    step("fp2b",     0, 0, 24'h000000,   3, word(3),  -1, word(3),  1, 1);
    step("hold0",    0, 0, 24'h000004,  -1, 0,         2, word(2),  1, 1);
    step("hold1",    0, 0, 24'h000000,   2, word(2),  -1, word(2),  1, 1);
    step("hold2",    0, 0, 24'h000000,  -1, 0,        -1, word(2),  1, 1);
    step("hold3",    0, 0, 24'h000000,  -1, 0,        -1, word(2),  1, 1);
    step("cclr",     0, 1, 24'h000000,  -1, 0,        -1, word(2),  1, 1);
    step("rr0",      0, 0, 24'h100020,  -1, 0,         5, word(5),  0, 0);
    step("rr1",      0, 0, 24'h100020,   5, word(5),  20, word(20), 1, 1);
    step("rr2",      0, 0, 24'h100020,   5, word(5),   5, word(5),  1, 2);
    step("rr3",      0, 0, 24'h100020,   5, word(5),  20, word(20), 1, 3);
    step("rr23",     0, 0, 24'h800000,   5, word(5),  23, word(23), 1, 4);
    step("wrap",     0, 0, 24'h400001,  23, word(23),  0, word(0),  1, 4);
    step("mdr",      0, 0, 24'h200000,   0, word(0),  21, word(21), 1, 5);
    step("cclr2",    0, 1, 24'h000000,  21, word(21), -1, word(21), 1, 5);
    for (int k = 0; k < 20; k++) begin
      step("sat", 0, 0, 24'h000003,
           (k == 0) ? -1 : 0, (k == 0) ? 32'd0 : word(0),
           k % 2, word(k % 2),
           (k != 0), (k < 15) ? k : 15);
    end
    step("satclr",   0, 1, 24'h000003,   0, word(0),   0, word(0),  1, 15);
    step("clrIdle",  0, 1, 24'h000000,   0, word(0),  -1, word(0),  1, 1);
    step("clrDone",  0, 0, 24'h000000,  -1, 0,        -1, word(0),  0, 0);
    step("rstMid",   1, 0, 24'h000200,  -1, 0,        -1, 0,        0, 0);
    step("postRst",  0, 0, 24'h000201,  -1, 0,         0, word(0),  0, 0);
    step("postRst2", 0, 0, 24'h000000,   0, word(0),  -1, word(0),  1, 1);

    for (int k = 0; k < 5 && expQ.size() > 0; k++) @(negedge clk);
    checks++;
    if (expQ.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", expQ.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
